// File: rtl/core_pkg.sv
// Shared encodings for the memory stage: result source select, load/store
// funct3 codes and the memory access FSM states.
package core_pkg;

    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } mem_state_e;

    // Word-aligns a byte address for the data bus.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for data memory: store lane alignment,
// byte enables, load extraction/extension and fault detection.
module mem_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [31:0] load_shift_s;

    assign load_shift_s = load_raw >> {addr_lo, 3'b000};

    // Store lane replication and byte enables.
    always_comb begin
        wdata = 32'h0000_0000;
        be    = 4'b0000;
        case (funct3)
            F3_B: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            F3_H: begin
                wdata = {2{store_data[15:0]}};
                be    = 4'b0011 << addr_lo;
            end
            F3_W: begin
                wdata = store_data;
                be    = 4'b1111;
            end
            default: begin
                wdata = 32'h0000_0000;
                be    = 4'b0000;
            end
        endcase
    end

    // Load lane extraction with sign or zero extension.
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            F3_B:    load_data = {{24{load_shift_s[7]}}, load_shift_s[7:0]};
            F3_H:    load_data = {{16{load_shift_s[15]}}, load_shift_s[15:0]};
            F3_W:    load_data = load_shift_s;
            F3_BU:   load_data = {24'h00_0000, load_shift_s[7:0]};
            F3_HU:   load_data = {16'h0000, load_shift_s[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Misalignment and illegal-width detection; a store wins over a load.
    always_comb begin
        fault = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B:    fault = 1'b0;
                F3_H:    fault = addr_lo[0];
                F3_W:    fault = (addr_lo != 2'b00);
                default: fault = 1'b1;
            endcase
        end else if (is_load) begin
            case (funct3)
                F3_B, F3_BU: fault = 1'b0;
                F3_H, F3_HU: fault = addr_lo[0];
                F3_W:        fault = (addr_lo != 2'b00);
                default:     fault = 1'b1;
            endcase
        end else begin
            fault = 1'b0;
        end
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: issues data-memory requests, stalls while an access
// is outstanding and registers results toward writeback.
module stage_memory
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] execute_alu_result,
    input  logic [31:0] execute_wr_datamem_data,
    input  logic [2:0]  execute_funct3,
    input  logic        execute_datamem_wr_enable,
    input  logic [1:0]  execute_result_src,
    input  logic [4:0]  execute_rd,
    input  logic        execute_regfile_wr_enable,
    input  logic [31:0] execute_instr_addr_plus,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [4:0]  mem_rd,
    output logic        mem_regfile_wr_enable,
    output logic [1:0]  mem_result_src,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_read_data,
    output logic [31:0] mem_instr_addr_plus,
    output logic        mem_misaligned
);

    mem_state_e  state_r, state_next_s;
    logic        is_store_s, is_load_s, fault_s, op_valid_s;
    logic        req_s, stall_s;
    logic [31:0] load_data_s;
    logic [31:0] read_data_next_s;

    assign is_store_s = execute_datamem_wr_enable;
    assign is_load_s  = (execute_result_src == RS_LOAD) && !execute_datamem_wr_enable;
    assign op_valid_s = (is_store_s || is_load_s) && !fault_s;

    mem_align u_align (
        .addr_lo    (execute_alu_result[1:0]),
        .funct3     (execute_funct3),
        .is_load    (is_load_s),
        .is_store   (is_store_s),
        .store_data (execute_wr_datamem_data),
        .load_raw   (dmem_rdata),
        .wdata      (dmem_wdata),
        .be         (dmem_be),
        .load_data  (load_data_s),
        .fault      (fault_s)
    );

    assign dmem_req  = req_s;
    assign dmem_we   = req_s && is_store_s;
    assign dmem_addr = word_addr(execute_alu_result);
    assign mem_stall = stall_s;

    // Access FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, bus request and stall; stall never depends on rdata.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid_s) begin
                    req_s = 1'b1;
                    if (dmem_gnt) begin
                        if (is_store_s) begin
                            state_next_s = ST_IDLE;
                            stall_s      = 1'b0;
                        end else begin
                            state_next_s = ST_RESP;
                            stall_s      = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                        stall_s      = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    state_next_s = ST_IDLE;
                    stall_s      = 1'b0;
                end else begin
                    state_next_s = ST_RESP;
                    stall_s      = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Load data is only meaningful on the cycle the response completes.
    always_comb begin
        if ((state_r == ST_RESP) && dmem_rvalid) begin
            read_data_next_s = load_data_s;
        end else begin
            read_data_next_s = 32'h0000_0000;
        end
    end

    // Output pipeline register; inserts a bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd                <= 5'd0;
            mem_regfile_wr_enable <= 1'b0;
            mem_result_src        <= RS_ALU;
            mem_alu_result        <= 32'h0000_0000;
            mem_read_data         <= 32'h0000_0000;
            mem_instr_addr_plus   <= 32'h0000_0000;
            mem_misaligned        <= 1'b0;
        end else if (!stall_s) begin
            mem_rd                <= execute_rd;
            mem_regfile_wr_enable <= execute_regfile_wr_enable && !fault_s;
            mem_result_src        <= execute_result_src;
            mem_alu_result        <= execute_alu_result;
            mem_read_data         <= read_data_next_s;
            mem_instr_addr_plus   <= execute_instr_addr_plus;
            mem_misaligned        <= fault_s;
        end else begin
            mem_rd                <= 5'd0;
            mem_regfile_wr_enable <= 1'b0;
            mem_result_src        <= RS_ALU;
            mem_alu_result        <= execute_alu_result;
            mem_read_data         <= 32'h0000_0000;
            mem_instr_addr_plus   <= execute_instr_addr_plus;
            mem_misaligned        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Directed self-checking bench for stage_memory.
module tb_stage_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] execute_alu_result;
    logic [31:0] execute_wr_datamem_data;
    logic [2:0]  execute_funct3;
    logic        execute_datamem_wr_enable;
    logic [1:0]  execute_result_src;
    logic [4:0]  execute_rd;
    logic        execute_regfile_wr_enable;
    logic [31:0] execute_instr_addr_plus;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [4:0]  mem_rd;
    logic        mem_regfile_wr_enable;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic [31:0] mem_instr_addr_plus;
    logic        mem_misaligned;

    int total = 0;
    int bad   = 0;

    stage_memory dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .execute_alu_result        (execute_alu_result),
        .execute_wr_datamem_data   (execute_wr_datamem_data),
        .execute_funct3            (execute_funct3),
        .execute_datamem_wr_enable (execute_datamem_wr_enable),
        .execute_result_src        (execute_result_src),
        .execute_rd                (execute_rd),
        .execute_regfile_wr_enable (execute_regfile_wr_enable),
        .execute_instr_addr_plus   (execute_instr_addr_plus),
        .dmem_req                  (dmem_req),
        .dmem_we                   (dmem_we),
        .dmem_addr                 (dmem_addr),
        .dmem_wdata                (dmem_wdata),
        .dmem_be                   (dmem_be),
        .dmem_gnt                  (dmem_gnt),
        .dmem_rvalid               (dmem_rvalid),
        .dmem_rdata                (dmem_rdata),
        .mem_stall                 (mem_stall),
        .mem_rd                    (mem_rd),
        .mem_regfile_wr_enable     (mem_regfile_wr_enable),
        .mem_result_src            (mem_result_src),
        .mem_alu_result            (mem_alu_result),
        .mem_read_data             (mem_read_data),
        .mem_instr_addr_plus       (mem_instr_addr_plus),
        .mem_misaligned            (mem_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [2:0] f3, input logic we, input logic [1:0] rs,
                          input logic [4:0] rd, input logic rwe, input logic [31:0] pc);
        execute_alu_result        = alu;
        execute_wr_datamem_data   = sdata;
        execute_funct3            = f3;
        execute_datamem_wr_enable = we;
        execute_result_src        = rs;
        execute_rd                = rd;
        execute_regfile_wr_enable = rwe;
        execute_instr_addr_plus   = pc;
    endtask

    task automatic nop();
        set_op(32'h0, 32'h0, 3'b000, 1'b0, 2'b00, 5'd0, 1'b0, 32'h0);
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        nop();
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_alu", mem_alu_result, 32'h0);
        chk("rst_rd", {27'd0, mem_rd}, 32'd0);
        chk("rst_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);
        chk("rst_mis", {31'd0, mem_misaligned}, 32'd0);
        #3 rst_n = 1'b1;
        step();

        // ADD passthrough
        set_op(32'h1234, 32'h0, 3'b000, 1'b0, 2'b00, 5'd5, 1'b1, 32'h44);
        #1;
        chk("add_stall", {31'd0, mem_stall}, 32'd0);
        chk("add_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("add_alu", mem_alu_result, 32'h1234);
        chk("add_rd", {27'd0, mem_rd}, 32'd5);
        chk("add_wen", {31'd0, mem_regfile_wr_enable}, 32'd1);
        chk("add_pc", mem_instr_addr_plus, 32'h44);

        // SB to byte lane 3, granted immediately
        set_op(32'h103, 32'hAB, 3'b000, 1'b1, 2'b00, 5'd0, 1'b0, 32'h48);
        dmem_gnt = 1'b1;
        #1;
        chk("sb_req", {31'd0, dmem_req}, 32'd1);
        chk("sb_we", {31'd0, dmem_we}, 32'd1);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_be", {28'd0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_stall", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_gnt = 1'b0;
        chk("sb_alu", mem_alu_result, 32'h103);
        chk("sb_mis", {31'd0, mem_misaligned}, 32'd0);

        // LB lane 2: gnt cycle 0, rvalid cycle 2
        set_op(32'h102, 32'h0, 3'b000, 1'b0, 2'b01, 5'd7, 1'b1, 32'h4C);
        dmem_gnt = 1'b1;
        #1;
        chk("lb_req", {31'd0, dmem_req}, 32'd1);
        chk("lb_we", {31'd0, dmem_we}, 32'd0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_stall0", {31'd0, mem_stall}, 32'd1);
        step();
        dmem_gnt = 1'b0;
        #1;
        chk("lb_stall1", {31'd0, mem_stall}, 32'd1);
        chk("lb_req_resp", {31'd0, dmem_req}, 32'd0);
        chk("lb_bubble_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);
        chk("lb_bubble_rd", {27'd0, mem_rd}, 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0080FF00;
        #1;
        chk("lb_stall2", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        nop();
        chk("lb_data", mem_read_data, 32'hFFFFFF80);
        chk("lb_rd", {27'd0, mem_rd}, 32'd7);
        chk("lb_wen", {31'd0, mem_regfile_wr_enable}, 32'd1);
        chk("lb_src", {30'd0, mem_result_src}, 32'd1);
        step();

        // LHU upper half with 3 cycles of withheld grant
        set_op(32'h2, 32'h0, 3'b101, 1'b0, 2'b01, 5'd9, 1'b1, 32'h50);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lhu_hold_req", {31'd0, dmem_req}, 32'd1);
            chk("lhu_hold_addr", dmem_addr, 32'h0);
            chk("lhu_hold_stall", {31'd0, mem_stall}, 32'd1);
            step();
        end
        dmem_gnt = 1'b1;
        #1;
        chk("lhu_gnt_req", {31'd0, dmem_req}, 32'd1);
        chk("lhu_gnt_stall", {31'd0, mem_stall}, 32'd1);
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBEEF0000;
        #1;
        chk("lhu_resp_req", {31'd0, dmem_req}, 32'd0);
        chk("lhu_resp_stall", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        nop();
        chk("lhu_data", mem_read_data, 32'h0000BEEF);
        chk("lhu_rd", {27'd0, mem_rd}, 32'd9);

        // Misaligned LW: no request, fault flag for one cycle
        set_op(32'h6, 32'h0, 3'b010, 1'b0, 2'b01, 5'd3, 1'b1, 32'h54);
        dmem_gnt = 1'b1;
        #1;
        chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
        chk("lw_mis_stall", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_gnt = 1'b0;
        nop();
        chk("lw_mis_flag", {31'd0, mem_misaligned}, 32'd1);
        chk("lw_mis_wen", {31'd0, mem_regfile_wr_enable}, 32'd0);
        chk("lw_mis_rd", {27'd0, mem_rd}, 32'd3);
        step();
        chk("lw_mis_clear", {31'd0, mem_misaligned}, 32'd0);

        // Reset during RESP, then a late rvalid
        set_op(32'h10, 32'h0, 3'b010, 1'b0, 2'b01, 5'd4, 1'b1, 32'h58);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #1;
        chk("rr_in_resp", {31'd0, mem_stall}, 32'd1);
        rst_n = 1'b0;
        nop();
        #1;
        chk("rr_stall", {31'd0, mem_stall}, 32'd0);
        chk("rr_alu", mem_alu_result, 32'h0);
        chk("rr_pc", mem_instr_addr_plus, 32'h0);
        chk("rr_src", {30'd0, mem_result_src}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        #1;
        chk("rr_rvalid_stall", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        chk("rr_rdata_drop", mem_read_data, 32'h0);
        set_op(32'h20, 32'h0, 3'b010, 1'b0, 2'b01, 5'd6, 1'b1, 32'h5C);
        #1;
        chk("rr_idle_req", {31'd0, dmem_req}, 32'd1);
        chk("rr_idle_stall", {31'd0, mem_stall}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
